// File: rtl/st_gain_offset_sat.sv
// Streaming gain/offset stage: y = sat(round(x*gain/2^FRAC_BITS) + offset).
// Two registered stages (product, then round/offset/clamp) with full valid/ready backpressure.
module st_gain_offset_sat #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int FRAC_BITS = 8,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic [COEF_W-1:0] gain,
  input  logic [DATA_W-1:0] offset,
  input  logic              sat_clr,
  output logic              sat_flag,
  output logic [CNT_W-1:0]  sat_count
);

  localparam int PW     = DATA_W + COEF_W;
  localparam int SW     = PW + 2;
  localparam int RND_SH = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;
  localparam logic [PW:0] RND = (FRAC_BITS > 0) ? ((PW+1)'(1) << RND_SH) : '0;
  localparam logic signed [SW-1:0] SMAX = {{(SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN = ~SMAX;

  // Handshake: a beat moves on valid && ready; a stage advances when it is
  // empty or its contents are leaving this cycle.
  logic s2_en, s1_en, s2_load;

  logic              s1_valid_q, s1_valid_d;
  logic [PW-1:0]     s1_prod_q, s1_prod_d;
  logic [DATA_W-1:0] s1_off_q, s1_off_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              sat_flag_q, sat_flag_d;
  logic [CNT_W-1:0]  sat_count_q, sat_count_d;

  logic [PW:0]            rsum;
  logic signed [PW:0]     r;
  logic signed [SW-1:0]   s;
  logic                   sat_hi, sat_lo;

  assign s2_en    = !out_valid_q || out_ready;
  assign s1_en    = !s1_valid_q || s2_en;
  assign s2_load  = s2_en && s1_valid_q;
  assign in_ready = s1_en;

  // Operands are sign-extended to the full product width so the most-negative
  // corner case (-2^(N-1) * -2^(M-1)) is representable.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_prod_d  = s1_prod_q;
    s1_off_d   = s1_off_q;
    if (s1_en) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_prod_d = $signed({{COEF_W{in_data[DATA_W-1]}}, in_data}) *
                    $signed({{DATA_W{gain[COEF_W-1]}}, gain});
        s1_off_d  = offset;
      end
    end
  end

  always_comb begin
    rsum   = {s1_prod_q[PW-1], s1_prod_q} + RND;
    r      = $signed(rsum) >>> FRAC_BITS;
    s      = {r[PW], r} + {{(SW-DATA_W){s1_off_q[DATA_W-1]}}, s1_off_q};
    sat_hi = s > SMAX;
    sat_lo = s < SMIN;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (s2_en) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        if (sat_hi)      out_data_d = SMAX[DATA_W-1:0];
        else if (sat_lo) out_data_d = SMIN[DATA_W-1:0];
        else             out_data_d = s[DATA_W-1:0];
      end
    end
  end

  // A clear wins over a saturation event landing in the same cycle.
  always_comb begin
    sat_flag_d  = sat_flag_q;
    sat_count_d = sat_count_q;
    if (sat_clr) begin
      sat_flag_d  = 1'b0;
      sat_count_d = '0;
    end else if (s2_load && (sat_hi || sat_lo)) begin
      sat_flag_d = 1'b1;
      if (sat_count_q != '1) sat_count_d = sat_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_prod_q   <= '0;
      s1_off_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sat_flag_q  <= 1'b0;
      sat_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_prod_q   <= s1_prod_d;
      s1_off_q    <= s1_off_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sat_flag_q  <= sat_flag_d;
      sat_count_q <= sat_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sat_flag  = sat_flag_q;
  assign sat_count = sat_count_q;

endmodule
